// File: rtl/descriptor_buffer.sv
// descriptor_buffer
//   Small synchronous FIFO between the frame-parser descriptor sender and the
//   lookup/queue manager. Descriptors arrive on a level-wr / pulse-ack
//   handshake, are stored in order, and are re-issued downstream with the same
//   protocol. Downstream stalls are absorbed; upstream is backpressured by
//   withholding ack while the FIFO is full.
//
// Ports
//   clk_sys                 in   1      system clock, rising edge
//   reset_n                 in   1      synchronous active-low reset
//   i_descriptor_wr         in   1      upstream valid, held until ack
//   iv_descriptor           in   DW     upstream descriptor
//   o_descriptor_ack        out  1      single-cycle accept pulse to upstream
//   o_descriptor_wr         out  1      downstream valid, held until i_descriptor_ack
//   ov_descriptor           out  DW     downstream descriptor (0 when not valid)
//   i_descriptor_ack        in   1      downstream accept pulse
//   ov_fifo_usedw           out  AW+1   FIFO occupancy, 0..DEPTH
//   o_fifo_full             out  1      occupancy == DEPTH
//   descriptor_buffer_state out  2      output FSM state (debug)
module descriptor_buffer #(
    parameter int DW    = 72,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          i_descriptor_wr,
    input  logic [DW-1:0] iv_descriptor,
    output logic          o_descriptor_ack,
    output logic          o_descriptor_wr,
    output logic [DW-1:0] ov_descriptor,
    input  logic          i_descriptor_ack,
    output logic [AW:0]   ov_fifo_usedw,
    output logic          o_fifo_full,
    output logic [1:0]    descriptor_buffer_state
);

    typedef enum logic [1:0] {
        IDLE_S     = 2'b00,
        WAIT_ACK_S = 2'b10
    } state_e;

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];

    state_e        state_q,   state_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW:0]   cnt_q,     cnt_d;
    logic          full_q,    full_d;
    logic          ack_q,     ack_d;
    logic          owr_q,     owr_d;
    logic [DW-1:0] odata_q,   odata_d;

    logic          push;
    logic          pop;

    // Input side: the ack_q term stops a second write in the cycle upstream
    // still holds wr while it is seeing the previous ack.
    always_comb begin
        push     = i_descriptor_wr && !ack_q && !full_q;
        ack_d    = push;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    end

    // Output FSM: a pop is the load of the head entry into the output register.
    always_comb begin
        state_d  = state_q;
        owr_d    = owr_q;
        odata_d  = odata_q;
        rd_ptr_d = rd_ptr_q;
        pop      = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (cnt_q != '0) begin
                    pop      = 1'b1;
                    odata_d  = mem_q[rd_ptr_q];
                    owr_d    = 1'b1;
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    state_d  = WAIT_ACK_S;
                end else begin
                    owr_d   = 1'b0;
                    odata_d = '0;
                end
            end
            WAIT_ACK_S: begin
                if (i_descriptor_ack) begin
                    owr_d   = 1'b0;
                    odata_d = '0;
                    state_d = IDLE_S;
                end
            end
            default: begin
                owr_d   = 1'b0;
                odata_d = '0;
                state_d = IDLE_S;
            end
        endcase
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d = (cnt_d == DEPTH_CNT);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q  <= IDLE_S;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            ack_q    <= 1'b0;
            owr_q    <= 1'b0;
            odata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            ack_q    <= ack_d;
            owr_q    <= owr_d;
            odata_q  <= odata_d;
        end
    end

    // Storage is not reset; contents are only read when occupancy says valid.
    always_ff @(posedge clk_sys) begin
        if (reset_n && push) begin
            mem_q[wr_ptr_q] <= iv_descriptor;
        end
    end

    assign o_descriptor_ack        = ack_q;
    assign o_descriptor_wr         = owr_q;
    assign ov_descriptor           = odata_q;
    assign ov_fifo_usedw           = cnt_q;
    assign o_fifo_full             = full_q;
    assign descriptor_buffer_state = state_q;

endmodule
